hyst_band_fsm: RTL and testbench
================================

Name: hyst_band_fsm

Overview:
- Parametrised successor to the 3-band threshold classifier FSM; classifies an unsigned W-bit sample into LOW / MID / HIGH bands with per-state hysteresis thresholds.
- Adds:
  - synchronous reset
  - input-valid qualification
  - N-sample debounce before any band change
  - one-cycle change-event pulse with the previous band
- Sits after a sensor/ADC sample register; its band output drives downstream alarm and control logic.

Parameters:
- W, 5: sample width in bits (unsigned).
- MID_TO_LOW, 12: in MID, inp < MID_TO_LOW targets LOW.
- MID_TO_HIGH, 20: in MID, inp > MID_TO_HIGH targets HIGH.
- LOW_TO_MID, 20: in LOW, LOW_TO_MID < inp <= LOW_TO_HIGH targets MID.
- LOW_TO_HIGH, 26: in LOW, inp > LOW_TO_HIGH targets HIGH.
- HIGH_TO_MID, 14: in HIGH, HIGH_TO_LOW <= inp < HIGH_TO_MID targets MID.
- HIGH_TO_LOW, 8: in HIGH, inp < HIGH_TO_LOW targets LOW.
- DEB_CNT, 2: consecutive qualifying valid samples required to change band; legal range >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- inp  input  W  sample value.
- inp_valid  input  1  sample qualifier; inp is ignored when low.
- s  output  2  current band: 2'b00 = MID, 2'b10 = LOW, 2'b01 = HIGH (2'b11 never driven).
- chg  output  1  one-cycle pulse, high in the cycle s first shows a new band.
- s_prev  output  2  band held before the most recent change.
- pend  output  1  high while a debounce sequence toward a different band is in progress.

Behaviour:
- All outputs are registered. Reset values: s = MID, s_prev = MID, chg = 0, pend = 0, debounce count = 0, pending target = MID.
- Target computation is combinational from (s, inp) using the thresholds above; all comparisons are unsigned at width W.
- If no rule for the current band fires, target = s. MID is self-holding for MID_TO_LOW <= inp <= MID_TO_HIGH.
- Debounce, evaluated on each rising edge with inp_valid = 1:
  - target == s: count <= 0; pend <= 0.
  - target != s and target == pending target: count increments.
  - target != s and target != pending target: pending target <= target; count <= 1.
  - When the updated count would reach DEB_CNT: s <= target, s_prev <= old s, chg <= 1, count <= 0, pend <= 0.
  - Otherwise pend <= 1.
- inp_valid = 0: count, pending target, s and pend hold; chg <= 0. Invalid cycles do not break a consecutive run.
- Latency: s changes at the edge that samples the DEB_CNT-th consecutive qualifying valid sample. With DEB_CNT = 1 the change lands at the first qualifying edge.
- chg is high exactly one cycle per change and is cleared on every edge without a change.
- Direct LOW<->HIGH jumps are legal single transitions; they never pass through MID.
- Target switching mid-debounce (e.g. MID pending LOW, then a HIGH-qualifying sample) restarts the count at 1 for the new target.
- Count width is ceil(log2(DEB_CNT+1)) and cannot overflow, because a change occurs at DEB_CNT.
- Reset asserted mid-debounce or in the same cycle as a would-be change: reset wins; all state returns to reset values.
- Parameter checks: elaboration-time error if DEB_CNT < 1 or any threshold > 2^W - 1.

Optional Feature:
- Macro: HYST_BAND_DWELL_EN.
- Defined: adds output dwell [15:0].
  - Cleared to 0 by reset and on every band change (the chg cycle shows 0).
  - Otherwise increments once per clock regardless of inp_valid, saturating at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with inp = 31, valid = 1 -> s = 00, chg = 0, pend = 0 throughout; band changes become possible only after rst falls.
- Debounce MID->LOW (defaults): valid samples 5, 5 -> pend = 1 after the first edge; s = 10, chg = 1, s_prev = 00 after the second edge; chg = 0 the next cycle.
- Interrupted run: in MID, valid 25, then 16, then 25 -> s stays 00, count restarts. Then 25, invalid cycle (inp = 0, valid = 0), 25 -> s = 01 (invalid cycle does not break the run).
- LOW jumps: in LOW, 27, 27 -> s = 01 directly (no MID visit). From HIGH, 10, 10 -> s = 00. From MID, 21, 21 -> s = 01; then 7, 7 -> s = 10.
- Target switch: in MID, 3 then 28 then 28 -> single change to 01 on the third edge; s_prev = 00.
- Reset mid-debounce: in MID, one sample 3, then rst for 1 cycle, then 3 -> s still 00, pend = 1 (count restarted at 1).

Source files
------------

// File: rtl/hyst_band_fsm.sv
// hyst_band_fsm
//   Three-band (LOW / MID / HIGH) classifier for an unsigned W-bit sample.
//   Each band has its own exit thresholds, which gives the hysteresis. A band
//   change is taken only after DEB_CNT consecutive qualifying valid samples.
//   Cycles with inp_valid low are skipped and do not break a run.
//
//   Optional feature: define HYST_BAND_DWELL_EN to add the dwell output. It
//   counts clocks spent in the current band and saturates at 16'hFFFF.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   inp       in   [W-1:0] sample value
//   inp_valid in   sample qualifier; inp is ignored when low
//   s         out  [1:0] current band: 00 = MID, 10 = LOW, 01 = HIGH
//   chg       out  one-cycle pulse in the first cycle s shows a new band
//   s_prev    out  [1:0] band held before the most recent change
//   pend      out  a debounce run toward a different band is in progress
//   dwell     out  [15:0] clocks since the last change (HYST_BAND_DWELL_EN only)
module hyst_band_fsm #(
  parameter int W           = 5,
  parameter int MID_TO_LOW  = 12,
  parameter int MID_TO_HIGH = 20,
  parameter int LOW_TO_MID  = 20,
  parameter int LOW_TO_HIGH = 26,
  parameter int HIGH_TO_MID = 14,
  parameter int HIGH_TO_LOW = 8,
  parameter int DEB_CNT     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inp,
  input  logic         inp_valid,
  output logic [1:0]   s,
  output logic         chg,
  output logic [1:0]   s_prev,
  output logic         pend
`ifdef HYST_BAND_DWELL_EN
  ,
  output logic [15:0]  dwell
`endif
);

  localparam logic [1:0] MID  = 2'b00;
  localparam logic [1:0] LOW  = 2'b10;
  localparam logic [1:0] HIGH = 2'b01;

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam longint MAXV = (longint'(1) << W) - 1;

  if (DEB_CNT < 1) begin : g_chk_deb
    $error("hyst_band_fsm: DEB_CNT must be >= 1");
  end
  if (MID_TO_LOW > MAXV || MID_TO_HIGH > MAXV || LOW_TO_MID > MAXV ||
      LOW_TO_HIGH > MAXV || HIGH_TO_MID > MAXV || HIGH_TO_LOW > MAXV) begin : g_chk_thr
    $error("hyst_band_fsm: threshold exceeds sample range");
  end

  localparam logic [W-1:0] T_ML = W'(MID_TO_LOW);
  localparam logic [W-1:0] T_MH = W'(MID_TO_HIGH);
  localparam logic [W-1:0] T_LM = W'(LOW_TO_MID);
  localparam logic [W-1:0] T_LH = W'(LOW_TO_HIGH);
  localparam logic [W-1:0] T_HM = W'(HIGH_TO_MID);
  localparam logic [W-1:0] T_HL = W'(HIGH_TO_LOW);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CNT);

  logic [1:0]    target;
  logic [1:0]    ptgt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          take;

  // Target band from current band and sample.
  always_comb begin
    target = s;
    case (s)
      MID: begin
        if (inp < T_ML)      target = LOW;
        else if (inp > T_MH) target = HIGH;
      end
      LOW: begin
        if (inp > T_LH)      target = HIGH;
        else if (inp > T_LM) target = MID;
      end
      HIGH: begin
        if (inp < T_HL)      target = LOW;
        else if (inp < T_HM) target = MID;
      end
      default: target = s;
    endcase
  end

  // A new target restarts the run at 1; the same target extends it.
  always_comb begin
    cnt_next = (target == ptgt) ? cnt + CW'(1) : CW'(1);
    take     = inp_valid && (target != s) && (cnt_next == CNT_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s      <= MID;
      s_prev <= MID;
      chg    <= 1'b0;
      pend   <= 1'b0;
      cnt    <= '0;
      ptgt   <= MID;
    end else begin
      chg <= 1'b0;
      if (inp_valid) begin
        if (target == s) begin
          cnt  <= '0;
          pend <= 1'b0;
        end else begin
          ptgt <= target;
          if (take) begin
            s      <= target;
            s_prev <= s;
            chg    <= 1'b1;
            cnt    <= '0;
            pend   <= 1'b0;
          end else begin
            cnt  <= cnt_next;
            pend <= 1'b1;
          end
        end
      end
    end
  end

`ifdef HYST_BAND_DWELL_EN
  always_ff @(posedge clk) begin
    if (rst || take)         dwell <= '0;
    else if (dwell != '1)    dwell <= dwell + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hyst_band_fsm.sv
// tb_hyst_band_fsm
//   Directed bench for hyst_band_fsm with default parameters. Each step drives
//   one cycle of stimulus and queues the outputs expected after that edge; the
//   entry is popped and checked one time unit after the edge.
module tb_hyst_band_fsm;

  localparam logic [1:0] MID  = 2'b00;
  localparam logic [1:0] LOW  = 2'b10;
  localparam logic [1:0] HIGH = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] inp;
  logic       inp_valid;
  logic [1:0] s;
  logic       chg;
  logic [1:0] s_prev;
  logic       pend;
`ifdef HYST_BAND_DWELL_EN
  logic [15:0] dwell;
`endif

  int total = 0;
  int bad   = 0;
  int step_no = 0;

  typedef struct {
    int         id;
    logic [1:0] s;
    logic       chg;
    logic [1:0] prev;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  hyst_band_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .inp_valid (inp_valid),
    .s         (s),
    .chg       (chg),
    .s_prev    (s_prev),
    .pend      (pend)
`ifdef HYST_BAND_DWELL_EN
    ,
    .dwell     (dwell)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic r, input logic [4:0] d, input logic v,
                      input logic [1:0] es, input logic ec,
                      input logic [1:0] ep, input logic epd);
    exp_t e;
    exp_t got;
    rst       = r;
    inp       = d;
    inp_valid = v;
    step_no++;
    e.id = step_no; e.s = es; e.chg = ec; e.prev = ep; e.pend = epd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    total++;
    assert (s === got.s) else begin
      bad++;
      $error("FAIL s step=%0d got=%b want=%b", got.id, s, got.s);
    end
    total++;
    assert (chg === got.chg) else begin
      bad++;
      $error("FAIL chg step=%0d got=%b want=%b", got.id, chg, got.chg);
    end
    total++;
    assert (s_prev === got.prev) else begin
      bad++;
      $error("FAIL s_prev step=%0d got=%b want=%b", got.id, s_prev, got.prev);
    end
    total++;
    assert (pend === got.pend) else begin
      bad++;
      $error("FAIL pend step=%0d got=%b want=%b", got.id, pend, got.pend);
    end
  endtask

  initial begin
    rst = 1'b1; inp = '0; inp_valid = 1'b0;
    // Reset held with a HIGH-qualifying sample: nothing may move.
    step(1, 31, 1, MID, 0, MID, 0);
    step(1, 31, 1, MID, 0, MID, 0);
    // MID -> LOW debounce
    step(0, 5, 1, MID, 0, MID, 1);
    step(0, 5, 1, LOW, 1, MID, 0);
    step(0, 5, 1, LOW, 0, MID, 0);
    // LOW -> MID (20 < inp <= 26)
    step(0, 22, 1, LOW, 0, MID, 1);
    step(0, 22, 1, MID, 1, LOW, 0);
    // Interrupted runs, then invalid cycle inside a run
    step(0, 25, 1, MID, 0, LOW, 1);
    step(0, 16, 1, MID, 0, LOW, 0);
    step(0, 25, 1, MID, 0, LOW, 1);
    step(0, 16, 1, MID, 0, LOW, 0);
    step(0, 25, 1, MID, 0, LOW, 1);
    step(0, 0,  0, MID, 0, LOW, 1);
    step(0, 25, 1, HIGH, 1, MID, 0);
    step(0, 0,  0, HIGH, 0, MID, 0);
    // HIGH -> MID
    step(0, 10, 1, HIGH, 0, MID, 1);
    step(0, 10, 1, MID, 1, HIGH, 0);
    // MID -> HIGH -> LOW
    step(0, 21, 1, MID, 0, HIGH, 1);
    step(0, 21, 1, HIGH, 1, MID, 0);
    step(0, 7,  1, HIGH, 0, MID, 1);
    step(0, 7,  1, LOW, 1, HIGH, 0);
    // Direct LOW -> HIGH
    step(0, 27, 1, LOW, 0, HIGH, 1);
    step(0, 27, 1, HIGH, 1, LOW, 0);
    step(0, 10, 1, HIGH, 0, LOW, 1);
    step(0, 10, 1, MID, 1, HIGH, 0);
    // Target switch mid-debounce restarts the count
    step(0, 3,  1, MID, 0, HIGH, 1);
    step(0, 28, 1, MID, 0, HIGH, 1);
    step(0, 28, 1, HIGH, 1, MID, 0);
    step(0, 10, 1, HIGH, 0, MID, 1);
    step(0, 10, 1, MID, 1, HIGH, 0);
    // MID hold boundaries 12 and 20
    step(0, 12, 1, MID, 0, HIGH, 0);
    step(0, 20, 1, MID, 0, HIGH, 0);
    step(0, 11, 1, MID, 0, HIGH, 1);
    step(0, 20, 1, MID, 0, HIGH, 0);
    // Reset mid-debounce
    step(0, 3, 1, MID, 0, HIGH, 1);
    step(1, 3, 1, MID, 0, MID, 0);
    step(0, 3, 1, MID, 0, MID, 1);
    step(0, 3, 1, LOW, 1, MID, 0);
    // LOW boundaries: 20 holds, 26 goes to MID
    step(0, 20, 1, LOW, 0, MID, 0);
    step(0, 26, 1, LOW, 0, MID, 1);
    step(0, 26, 1, MID, 1, LOW, 0);
    // Reset on the cycle of a would-be change
    step(0, 3,  1, MID, 0, LOW, 1);
    step(1, 3,  1, MID, 0, MID, 0);
    step(0, 15, 1, MID, 0, MID, 0);
    // HIGH boundaries: 14 holds, 8 goes to MID not LOW
    step(0, 31, 1, MID, 0, MID, 1);
    step(0, 31, 1, HIGH, 1, MID, 0);
    step(0, 14, 1, HIGH, 0, MID, 0);
    step(0, 8,  1, HIGH, 0, MID, 1);
    step(0, 8,  1, MID, 1, HIGH, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
